// File: rtl/neuron_mac_datapath_if.sv
// Bus between the neuron control unit and its MAC datapath: pair writes, threshold load, MAC enables, result.
// Latency: none, plain wires; the datapath registers everything behind it.
// Backpressure: none; output_ready only qualifies the result outputs, it never stalls the pipeline.
//
// master = control unit side, slave = neuron_mac_datapath side.
interface neuron_mac_datapath_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
);
    logic                     rst_mem;
    logic                     wr_en;
    logic        [5:0]        wr_data_ptr;
    logic signed [DATA_W-1:0] data_in;
    logic signed [DATA_W-1:0] weight_in;
    logic                     thr_wr;
    logic signed [ACC_W-1:0]  thr_in;
    logic                     threshold_ready;
    logic                     mul_mem_en;
    logic                     ac_mem_en;
    logic        [5:0]        rd_data_ptr;
    logic                     output_ready;
    logic signed [ACC_W-1:0]  acc_out;
    logic                     fire;
    logic                     result_valid;

    modport master (
        output rst_mem, wr_en, wr_data_ptr, data_in, weight_in, thr_wr, thr_in,
               mul_mem_en, ac_mem_en, rd_data_ptr, output_ready,
        input  threshold_ready, acc_out, fire, result_valid
    );

    modport slave (
        input  rst_mem, wr_en, wr_data_ptr, data_in, weight_in, thr_wr, thr_in,
               mul_mem_en, ac_mem_en, rd_data_ptr, output_ready,
        output threshold_ready, acc_out, fire, result_valid
    );
endinterface

// File: rtl/neuron_mac_datapath.sv
// Neuron MAC datapath: stores input/weight pairs and a threshold, saturating multiply-accumulate, fire compare.
// Latency: enable in cycle N -> product reg end of N -> acc updated end of N+1; DONE two idle cycles later.
// Backpressure: none; control paces the enables, output_ready only gates result_valid/acc_out/fire.
//
// Ports: clk, rst_n (async active-low) plus bus (slave modport): write port (wr_en, wr_data_ptr,
// data_in, weight_in), threshold load (thr_wr, thr_in, threshold_ready), MAC enables
// (mul_mem_en, ac_mem_en, rd_data_ptr, rst_mem) and result (output_ready, result_valid, acc_out, fire).
module neuron_mac_datapath #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int DEPTH  = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    neuron_mac_datapath_if.slave bus
);
    localparam int PROD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ARMED = 2'd1,
        S_ACCUM = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Pair memories: no reset, no read-during-write bypass (a same-cycle read sees the old word).
    logic signed [DATA_W-1:0] x_mem [DEPTH];
    logic signed [DATA_W-1:0] w_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            x_mem[bus.wr_data_ptr] <= bus.data_in;
            w_mem[bus.wr_data_ptr] <= bus.weight_in;
        end
    end

    logic signed [PROD_W-1:0] prod_d;
    logic signed [PROD_W-1:0] p_q;
    logic                     v1_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_sat;
    logic signed [ACC_W:0]    sum;
    logic                     ovf;
    logic                     sat_flag_q;

    assign prod_d = PROD_W'(x_mem[bus.rd_data_ptr]) * PROD_W'(w_mem[bus.rd_data_ptr]);

    // One guard bit above the accumulator: a disagreement between the top two bits is an overflow.
    assign sum = (ACC_W+1)'(acc_q) + (ACC_W+1)'(p_q);

    always_comb begin
        acc_sat = sum[ACC_W-1:0];
        ovf     = 1'b0;
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            ovf     = 1'b1;
            acc_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // rst_mem has priority over both stages, so an accumulate landing in the same cycle is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q        <= '0;
            v1_q       <= 1'b0;
            acc_q      <= '0;
            sat_flag_q <= 1'b0;
        end else if (bus.rst_mem) begin
            p_q        <= '0;
            v1_q       <= 1'b0;
            acc_q      <= '0;
            sat_flag_q <= 1'b0;
        end else begin
            if (bus.mul_mem_en) begin
                p_q <= prod_d;
            end
            v1_q <= bus.mul_mem_en & bus.ac_mem_en;
            if (v1_q) begin
                acc_q      <= acc_sat;
                sat_flag_q <= sat_flag_q | ovf;
            end
        end
    end

    state_t                  state_q, state_d;
    logic                    idle_q, idle_d;
    logic signed [ACC_W-1:0] thr_q, thr_d;
    logic                    fire_q, fire_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            idle_q  <= 1'b0;
            thr_q   <= '0;
            fire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            thr_q   <= thr_d;
            fire_q  <= fire_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idle_d  = 1'b0;
        thr_d   = thr_q;
        fire_d  = fire_q;
        case (state_q)
            S_EMPTY: begin
                if (bus.thr_wr) begin
                    thr_d   = bus.thr_in;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (bus.thr_wr) begin
                    thr_d = bus.thr_in;
                end
                if (v1_q) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                // Threshold is frozen while accumulating. Two idle cycles in a row mean the
                // pipeline has drained and acc_q is final, so fire is sampled on the way into DONE.
                if (!bus.mul_mem_en && !v1_q) begin
                    if (idle_q) begin
                        state_d = S_DONE;
                        fire_d  = (acc_q >= thr_q);
                    end else begin
                        idle_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (bus.thr_wr) begin
                    thr_d = bus.thr_in;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (bus.rst_mem && (state_q != S_EMPTY)) begin
            state_d = S_ARMED;
            idle_d  = 1'b0;
            fire_d  = 1'b0;
        end
    end

    assign bus.threshold_ready = (state_q != S_EMPTY);
    assign bus.result_valid    = bus.output_ready & (state_q == S_DONE);
    assign bus.acc_out         = bus.result_valid ? acc_q : '0;
    assign bus.fire            = bus.result_valid & fire_q;

endmodule

// File: tb/tb_neuron_mac_datapath.sv
module tb_neuron_mac_datapath;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    neuron_mac_datapath_if #(.DATA_W(8), .ACC_W(24)) b();
    neuron_mac_datapath_if #(.DATA_W(8), .ACC_W(16)) b16();

    // The narrow-accumulator instance sees exactly the same control stream.
    assign b16.rst_mem      = b.rst_mem;
    assign b16.wr_en        = b.wr_en;
    assign b16.wr_data_ptr  = b.wr_data_ptr;
    assign b16.data_in      = b.data_in;
    assign b16.weight_in    = b.weight_in;
    assign b16.thr_wr       = b.thr_wr;
    assign b16.thr_in       = b.thr_in[15:0];
    assign b16.mul_mem_en   = b.mul_mem_en;
    assign b16.ac_mem_en    = b.ac_mem_en;
    assign b16.rd_data_ptr  = b.rd_data_ptr;
    assign b16.output_ready = b.output_ready;

    neuron_mac_datapath #(.DATA_W(8), .ACC_W(24), .DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b.slave)
    );
    neuron_mac_datapath #(.DATA_W(8), .ACC_W(16), .DEPTH(64)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(b16.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic signed [7:0] x;
        logic signed [7:0] w;
        int                thr;
        int                exp_acc;
        bit                exp_fire;
    } vec_t;

    vec_t vecs[8];

    // All tasks start and end just after a falling edge.
    task automatic load_thr(input int t);
        b.thr_wr = 1'b1;
        b.thr_in = t[23:0];
        @(negedge clk);
        b.thr_wr = 1'b0;
    endtask

    task automatic pulse_rst_mem();
        b.rst_mem = 1'b1;
        @(negedge clk);
        b.rst_mem = 1'b0;
    endtask

    task automatic write_fill(input logic signed [7:0] x, input logic signed [7:0] w);
        for (int i = 0; i < 64; i++) begin
            b.wr_en       = 1'b1;
            b.wr_data_ptr = 6'(i);
            b.data_in     = x;
            b.weight_in   = w;
            @(negedge clk);
        end
        b.wr_en = 1'b0;
    endtask

    task automatic run_macs(input int n, input logic ac);
        for (int i = 0; i < n; i++) begin
            b.mul_mem_en  = 1'b1;
            b.ac_mem_en   = ac;
            b.rd_data_ptr = 6'(i);
            @(negedge clk);
        end
        b.mul_mem_en = 1'b0;
        b.ac_mem_en  = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int k = 0;
        while (!b.result_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, "_valid"}, b.result_valid, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp;
        vecs[0] = '{x:  1,   w:  2,   thr: 100,     exp_acc: 128,      exp_fire: 1'b1};
        vecs[1] = '{x:  1,   w:  2,   thr: 129,     exp_acc: 128,      exp_fire: 1'b0};
        vecs[2] = '{x:  1,   w:  2,   thr: 128,     exp_acc: 128,      exp_fire: 1'b1};
        vecs[3] = '{x: -1,   w:  2,   thr: -128,    exp_acc: -128,     exp_fire: 1'b1};
        vecs[4] = '{x: -1,   w:  2,   thr: -127,    exp_acc: -128,     exp_fire: 1'b0};
        vecs[5] = '{x: -128, w: -128, thr: 1048576, exp_acc: 1048576,  exp_fire: 1'b1};
        vecs[6] = '{x:  127, w:  127, thr: 0,       exp_acc: 1032256,  exp_fire: 1'b1};
        vecs[7] = '{x: -128, w:  127, thr: 0,       exp_acc: -1040384, exp_fire: 1'b0};

        b.rst_mem = 0; b.wr_en = 0; b.wr_data_ptr = '0; b.data_in = '0; b.weight_in = '0;
        b.thr_wr = 0; b.thr_in = '0; b.mul_mem_en = 0; b.ac_mem_en = 0; b.rd_data_ptr = '0;
        b.output_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_thr_ready", b.threshold_ready, 0);
        check("rst_valid", b.result_valid, 0);
        check("rst_acc", b.acc_out, 0);
        check("rst_fire", b.fire, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // threshold_ready rises the cycle after thr_wr
        b.thr_wr = 1'b1;
        b.thr_in = 24'd100;
        #1 check("thr_ready_same_cycle", b.threshold_ready, 0);
        @(negedge clk);
        b.thr_wr = 1'b0;
        check("thr_ready_next_cycle", b.threshold_ready, 1);

        for (int i = 0; i < 8; i++) begin
            load_thr(vecs[i].thr);
            pulse_rst_mem();
            write_fill(vecs[i].x, vecs[i].w);
            run_macs(64, 1'b1);
            wait_result($sformatf("vec%0d", i));
            check($sformatf("vec%0d_acc", i), b.acc_out, vecs[i].exp_acc);
            check($sformatf("vec%0d_fire", i), b.fire, vecs[i].exp_fire);
            if (vecs[i].x == -8'sd128 && vecs[i].w == 8'sd127) begin
                check("sat16_acc", b16.acc_out, -32768);
                check("sat16_flag", dut16.sat_flag_q, 1);
                check("sat16_fire", b16.fire, 0);
                check("sat24_flag", dut.sat_flag_q, 0);
            end
        end

        // Ramp data, equality fire, hold in DONE, output_ready gating
        load_thr(-96);
        pulse_rst_mem();
        for (int i = 0; i < 64; i++) begin
            b.wr_en = 1'b1; b.wr_data_ptr = 6'(i);
            b.data_in = 8'(i - 32); b.weight_in = 8'sd3;
            @(negedge clk);
        end
        b.wr_en = 1'b0;
        exp = 0;
        for (int i = 0; i < 64; i++) exp += (i - 32) * 3;
        run_macs(64, 1'b1);
        wait_result("ramp");
        check("ramp_acc", b.acc_out, exp);
        check("ramp_fire", b.fire, 1);
        repeat (3) @(negedge clk);
        check("ramp_hold_acc", b.acc_out, exp);
        b.output_ready = 1'b0;
        #1;
        check("gate_valid", b.result_valid, 0);
        check("gate_acc", b.acc_out, 0);
        check("gate_fire", b.fire, 0);
        b.output_ready = 1'b1;
        @(negedge clk);

        // Multiply without accumulate is discarded and never leaves ARMED
        load_thr(100);
        pulse_rst_mem();
        write_fill(8'sd1, 8'sd2);
        run_macs(10, 1'b0);
        repeat (4) @(negedge clk);
        check("mulonly_acc", dut.acc_q, 0);
        check("mulonly_state", dut.state_q, 1);
        check("mulonly_valid", b.result_valid, 0);
        run_macs(64, 1'b1);
        wait_result("mulonly_rerun");
        check("mulonly_rerun_acc", b.acc_out, 128);

        // rst_mem on the 30th enable: back to ARMED with threshold kept
        load_thr(100);
        pulse_rst_mem();
        for (int i = 0; i < 30; i++) begin
            b.mul_mem_en = 1'b1; b.ac_mem_en = 1'b1; b.rd_data_ptr = 6'(i);
            b.rst_mem = (i == 29);
            @(negedge clk);
        end
        b.mul_mem_en = 1'b0; b.ac_mem_en = 1'b0; b.rst_mem = 1'b0;
        repeat (3) @(negedge clk);
        check("rstmem_acc", dut.acc_q, 0);
        check("rstmem_state", dut.state_q, 1);
        check("rstmem_thr_ready", b.threshold_ready, 1);
        check("rstmem_thr", dut.thr_q, 100);
        check("rstmem_valid", b.result_valid, 0);
        run_macs(64, 1'b1);
        wait_result("rstmem_rerun");
        check("rstmem_rerun_acc", b.acc_out, 128);
        check("rstmem_rerun_fire", b.fire, 1);

        // thr_wr during ACCUM is ignored
        load_thr(129);
        pulse_rst_mem();
        for (int i = 0; i < 64; i++) begin
            b.mul_mem_en = 1'b1; b.ac_mem_en = 1'b1; b.rd_data_ptr = 6'(i);
            b.thr_wr = (i == 20);
            b.thr_in = '0;
            @(negedge clk);
        end
        b.mul_mem_en = 1'b0; b.ac_mem_en = 1'b0; b.thr_wr = 1'b0;
        wait_result("thr_accum");
        check("thr_accum_acc", b.acc_out, 128);
        check("thr_accum_fire", b.fire, 0);
        check("thr_accum_thr", dut.thr_q, 129);

        // Same-cycle write and read of one address returns the old word
        load_thr(0);
        pulse_rst_mem();
        b.wr_en = 1'b1; b.wr_data_ptr = 6'd5; b.data_in = 8'sd100; b.weight_in = 8'sd1;
        b.mul_mem_en = 1'b1; b.ac_mem_en = 1'b1; b.rd_data_ptr = 6'd5;
        @(negedge clk);
        b.wr_en = 1'b0; b.mul_mem_en = 1'b0; b.ac_mem_en = 1'b0;
        wait_result("rdw_old");
        check("rdw_old_acc", b.acc_out, 2);
        load_thr(0);
        pulse_rst_mem();
        b.mul_mem_en = 1'b1; b.ac_mem_en = 1'b1; b.rd_data_ptr = 6'd5;
        @(negedge clk);
        b.mul_mem_en = 1'b0; b.ac_mem_en = 1'b0;
        wait_result("rdw_new");
        check("rdw_new_acc", b.acc_out, 100);

        // rst_n mid-ACCUM clears everything including the threshold
        load_thr(100);
        pulse_rst_mem();
        run_macs(20, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_acc_out", b.acc_out, 0);
        check("arst_fire", b.fire, 0);
        check("arst_valid", b.result_valid, 0);
        check("arst_thr_ready", b.threshold_ready, 0);
        check("arst_acc_q", dut.acc_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("arst_thr_ready_after", b.threshold_ready, 0);
        check("arst_thr_q", dut.thr_q, 0);
        write_fill(8'sd1, 8'sd2);
        load_thr(100);
        check("arst_reload_ready", b.threshold_ready, 1);
        pulse_rst_mem();
        run_macs(64, 1'b1);
        wait_result("arst_rerun");
        check("arst_rerun_acc", b.acc_out, 128);
        check("arst_rerun_fire", b.fire, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
